// File: rtl/gcm_pkg.sv
// Shared types for the GCM decrypt path: block width, block type and the
// tag-gate controller states.
package gcm_pkg;

    localparam int GCM_BLK_W = 128;

    typedef logic [GCM_BLK_W-1:0] gcm_blk_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WAIT_EXP,
        ST_COMPARE,
        ST_RELEASE,
        ST_FLUSH
    } gcm_tag_gate_state_e;

endpackage

// File: rtl/gcm_blk_fifo.sv
// Synchronous show-ahead FIFO of 128-bit blocks. Pointers carry one extra
// MSB so that full and empty can be told apart when the indices are equal.
module gcm_blk_fifo
    import gcm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [GCM_BLK_W-1:0]   data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [GCM_BLK_W-1:0]   head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    gcm_blk_t     mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o = wr_ptr - rd_ptr;
    assign head_o  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards all stored blocks in a single cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/gcm_tag_gate.sv
// Holds decrypted plaintext until the computed GCM tag has been compared
// against the host's expected tag; releases it on a match, discards it
// otherwise.
module gcm_tag_gate
    import gcm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exp_tag_vld_i,
    input  logic [GCM_BLK_W-1:0] exp_tag_i,
    input  logic                 gcm_data_vld_i,
    input  logic                 gcm_tag_vld_i,
    input  logic [GCM_BLK_W-1:0] gcm_data_i,
    output logic                 busy_o,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic [GCM_BLK_W-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 ok_vld_o,
    output logic                 ok_o,
    output logic                 err_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    gcm_tag_gate_state_e state;
    gcm_blk_t            exp_tag;
    gcm_blk_t            calc_tag;
    logic                exp_have;
    logic                ovf;
    logic                err;
    logic                ok_vld;
    logic                ok;

    logic                collecting;
    logic                match;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    gcm_blk_t            fifo_head;

    assign collecting = (state == ST_IDLE) || (state == ST_COLLECT);
    assign busy_o     = (state == ST_COMPARE) || (state == ST_RELEASE) || (state == ST_FLUSH);
    assign fifo_push  = collecting && gcm_data_vld_i;
    assign fifo_flush = (state == ST_FLUSH);
    assign out_vld_o  = (state == ST_RELEASE) && !fifo_empty;
    assign fifo_pop   = out_vld_o && out_rdy_i;
    assign out_last_o = out_vld_o && (fifo_count == CW'(1));
    assign out_data_o = out_vld_o ? fifo_head : '0;
    assign ok_vld_o   = ok_vld;
    assign ok_o       = ok;
    assign err_o      = err;

    // Full-width XOR/OR reduction: the verdict never depends on where tags differ.
    assign match = ~|(calc_tag ^ exp_tag) & ~ovf;

    gcm_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (gcm_data_i),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Message controller: tag capture, expected-tag register, verdict and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            exp_tag  <= '0;
            calc_tag <= '0;
            exp_have <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            ok_vld   <= 1'b0;
            ok       <= 1'b0;
        end else begin
            ok_vld <= 1'b0;
            ok     <= 1'b0;

            if (exp_tag_vld_i && (state != ST_COMPARE)) begin
                exp_tag  <= exp_tag_i;
                exp_have <= 1'b1;
            end

            if (busy_o && (gcm_data_vld_i || gcm_tag_vld_i)) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (gcm_data_vld_i && fifo_full) begin
                        ovf <= 1'b1;
                    end
                    // A strobe on the same edge as the tag counts as already held.
                    if (gcm_tag_vld_i) begin
                        calc_tag <= gcm_data_i;
                        state    <= (exp_have || exp_tag_vld_i) ? ST_COMPARE : ST_WAIT_EXP;
                    end else if (gcm_data_vld_i) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_WAIT_EXP: begin
                    if (gcm_tag_vld_i) begin
                        err <= 1'b1;
                    end
                    if (exp_tag_vld_i) begin
                        state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    exp_have <= 1'b0;
                    ovf      <= 1'b0;
                    ok_vld   <= 1'b1;
                    ok       <= match;
                    state    <= match ? ST_RELEASE : ST_FLUSH;
                end
                ST_RELEASE: begin
                    if (fifo_empty || (fifo_pop && (fifo_count == CW'(1)))) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
